// File: rtl/eth_l2_header_parser_pkg.sv
// Shared types, constants and parser state encoding for the layer-2 receive path.
package eth_pkg;

   typedef logic [47:0] mac_t;
   typedef logic [15:0] ethertype_t;

   localparam int unsigned ETH_HDR_LEN   = 14;
   localparam mac_t        MAC_BROADCAST = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_DISCARD
   } parse_state_t;

endpackage

// File: rtl/eth_l2_header_parser_mac_match.sv
// Registered destination-address match against the station address or broadcast.
module eth_mac_match
   import eth_pkg::*;
#(
   parameter mac_t LOCAL_MAC = 48'h02_00_00_00_00_01
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  mac_t i_dst,
   output logic o_match
);

   logic r_match;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_match <= 1'b0;
      end else if (i_load) begin
         r_match <= (i_dst == LOCAL_MAC) || (i_dst == MAC_BROADCAST);
      end
   end

   assign o_match = r_match;

endmodule

// File: rtl/eth_l2_header_parser.sv
// Ethernet L2 header parser: captures dst/src/ethertype, forwards payload, counts runts.
// Optional destination filter enabled by defining ETH_L2_MAC_FILTER_EN.
module eth_l2_header_parser
   import eth_pkg::*;
#(
   parameter mac_t        LOCAL_MAC  = 48'h02_00_00_00_00_01,
   parameter int unsigned DROP_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   input  logic                  in_error,
   output logic                  hdr_valid,
   output mac_t                  dst_mac,
   output mac_t                  src_mac,
   output ethertype_t            ethertype,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   output logic                  out_last,
   output logic                  out_error,
   output logic [DROP_CNT_W-1:0] drop_count
);

   localparam logic [3:0] LAST_HDR_IDX = 4'(ETH_HDR_LEN - 1);

   parse_state_t            r_state;
   parse_state_t            w_state_nx;
   logic [3:0]              r_cnt;
   logic [3:0]              w_cnt_nx;
   logic [103:0]            r_sr;
   logic                    r_hdr_valid;
   mac_t                    r_dst;
   mac_t                    r_src;
   ethertype_t              r_type;
   logic [7:0]              r_out_data;
   logic                    r_out_valid;
   logic                    r_out_last;
   logic                    r_out_error;
   logic [DROP_CNT_W-1:0]   r_drop;

   logic                    w_shift;
   logic                    w_hdr_done;
   logic                    w_drop;
   logic                    w_fwd;
   logic                    w_accept;

`ifdef ETH_L2_MAC_FILTER_EN
   logic w_match_load;

   // dst sits in the low 48 bits of the shifter exactly while byte 6 is presented
   assign w_match_load = in_valid && (r_state == ST_HDR) && (r_cnt == 4'd6);

   eth_mac_match #(
      .LOCAL_MAC (LOCAL_MAC)
   ) u_mac_match (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_match_load),
      .i_dst   (r_sr[47:0]),
      .o_match (w_accept)
   );
`else
   logic w_unused_local_mac;

   assign w_unused_local_mac = ^LOCAL_MAC;
   assign w_accept           = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_shift    = 1'b0;
      w_hdr_done = 1'b0;
      w_drop     = 1'b0;
      w_fwd      = 1'b0;
      case (r_state)
         ST_IDLE, ST_HDR: begin
            if (in_valid) begin
               w_shift = 1'b1;
               if (in_last) begin
                  w_drop     = 1'b1;
                  w_state_nx = ST_IDLE;
                  w_cnt_nx   = '0;
               end else if (r_cnt == LAST_HDR_IDX) begin
                  w_cnt_nx = '0;
                  if (w_accept) begin
                     w_hdr_done = 1'b1;
                     w_state_nx = ST_PAYLOAD;
                  end else begin
                     w_drop     = 1'b1;
                     w_state_nx = ST_DISCARD;
                  end
               end else begin
                  w_cnt_nx   = r_cnt + 4'd1;
                  w_state_nx = ST_HDR;
               end
            end
         end
         ST_PAYLOAD: begin
            if (in_valid) begin
               w_fwd = 1'b1;
               if (in_last) begin
                  w_state_nx = ST_IDLE;
               end
            end
         end
         ST_DISCARD: begin
            if (in_valid && in_last) begin
               w_state_nx = ST_IDLE;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr        <= '0;
         r_hdr_valid <= 1'b0;
         r_dst       <= '0;
         r_src       <= '0;
         r_type      <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_error <= 1'b0;
         r_drop      <= '0;
      end else begin
         r_hdr_valid <= w_hdr_done;
         r_out_valid <= w_fwd;
         r_out_last  <= w_fwd & in_last;
         r_out_error <= w_fwd & in_last & in_error;
         if (w_fwd) begin
            r_out_data <= in_data;
         end
         if (w_shift) begin
            r_sr <= {r_sr[95:0], in_data};
         end
         // byte 13 completes the header; fields are taken straight from shifter + live byte
         if (w_hdr_done) begin
            {r_dst, r_src, r_type} <= {r_sr, in_data};
         end
         if (w_drop && (r_drop != '1)) begin
            r_drop <= r_drop + DROP_CNT_W'(1);
         end
      end
   end

   assign hdr_valid  = r_hdr_valid;
   assign dst_mac    = r_dst;
   assign src_mac    = r_src;
   assign ethertype  = r_type;
   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign out_last   = r_out_last;
   assign out_error  = r_out_error;
   assign drop_count = r_drop;

endmodule

// File: tb/tb_eth_l2_header_parser.sv
// Self-checking bench for eth_l2_header_parser: frame-level reference model plus directed cases.
module tb_eth_l2_header_parser;

   localparam logic [47:0] LMAC   = 48'h02_00_00_00_00_01;
   localparam logic [47:0] BCAST  = 48'hff_ff_ff_ff_ff_ff;
   localparam int unsigned DW     = 3;
   localparam int unsigned DMAX   = (1 << DW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          in_error = 1'b0;
   logic          hdr_valid;
   logic [47:0]   dst_mac;
   logic [47:0]   src_mac;
   logic [15:0]   ethertype;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_last;
   logic          out_error;
   logic [DW-1:0] drop_count;

   eth_l2_header_parser #(
      .LOCAL_MAC  (LMAC),
      .DROP_CNT_W (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_error   (in_error),
      .hdr_valid  (hdr_valid),
      .dst_mac    (dst_mac),
      .src_mac    (src_mac),
      .ethertype  (ethertype),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .out_error  (out_error),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int unsigned cyc; logic [47:0] dst; logic [47:0] src; logic [15:0] et; } hdr_t;
   typedef struct { int unsigned cyc; logic [7:0] d; logic last; logic err; } pl_t;
   typedef struct { int unsigned cyc; int unsigned val; } drp_t;

   hdr_t        hq[$];
   pl_t         pq[$];
   drp_t        dq[$];
   logic [7:0]  frame_q[$];
   int unsigned hdr_cycles[$];

   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned exp_drop_m = 0;
   int unsigned exp_drop = 0;
   int unsigned out_cnt = 0;
   int unsigned hdr_cnt = 0;
   logic [7:0]  last_out_data = '0;
   logic        last_out_err = 1'b0;

   function automatic bit mac_ok(input logic [47:0] d);
`ifdef ETH_L2_MAC_FILTER_EN
      return (d == LMAC) || (d == BCAST);
`else
      return 1'b1;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_drop(input int unsigned c);
      if (exp_drop_m < DMAX) exp_drop_m++;
      dq.push_back('{c + 1, exp_drop_m});
   endtask

   // compare process: every cycle, outputs vs. the model's timestamped expectations
   always @(negedge clk) begin
      hdr_t h;
      pl_t  p;
      if (hdr_valid) begin
         total++;
         if (hq.size() == 0) begin
            bad++;
            $display("FAIL hdr_unexpected: got hdr_valid=1 expected 0 (cycle %0d)", cyc);
         end else begin
            h = hq.pop_front();
            if (h.cyc != cyc || dst_mac !== h.dst || src_mac !== h.src || ethertype !== h.et) begin
               bad++;
               $display("FAIL hdr: got cyc=%0d dst=%h src=%h type=%h expected cyc=%0d dst=%h src=%h type=%h",
                        cyc, dst_mac, src_mac, ethertype, h.cyc, h.dst, h.src, h.et);
            end
         end
         hdr_cycles.push_back(cyc);
         hdr_cnt++;
      end else if (hq.size() > 0 && hq[0].cyc <= cyc) begin
         total++;
         bad++;
         $display("FAIL hdr_missing: got hdr_valid=0 expected 1 at cycle %0d", hq[0].cyc);
         void'(hq.pop_front());
      end
      if (out_valid) begin
         total++;
         if (pq.size() == 0) begin
            bad++;
            $display("FAIL out_unexpected: got out_valid=1 data=%h expected none (cycle %0d)", out_data, cyc);
         end else begin
            p = pq.pop_front();
            if (p.cyc != cyc || out_data !== p.d || out_last !== p.last || (p.last && out_error !== p.err)) begin
               bad++;
               $display("FAIL out: got cyc=%0d d=%h last=%b err=%b expected cyc=%0d d=%h last=%b err=%b",
                        cyc, out_data, out_last, out_error, p.cyc, p.d, p.last, p.err);
            end
         end
         out_cnt++;
         if (out_last) begin
            last_out_data = out_data;
            last_out_err  = out_error;
         end
      end else if (pq.size() > 0 && pq[0].cyc <= cyc) begin
         total++;
         bad++;
         $display("FAIL out_missing: got out_valid=0 expected data %h at cycle %0d", pq[0].d, pq[0].cyc);
         void'(pq.pop_front());
      end
      while (dq.size() > 0 && dq[0].cyc <= cyc) exp_drop = dq.pop_front().val;
      total++;
      if (drop_count !== DW'(exp_drop)) begin
         bad++;
         $display("FAIL drop_count: got %0d expected %0d (cycle %0d)", drop_count, exp_drop, cyc);
      end
   end

   task automatic build(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                        input int unsigned plen, input bit inc);
      frame_q = {};
      for (int i = 0; i < 6; i++) frame_q.push_back(d[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) frame_q.push_back(s[47-8*i -: 8]);
      frame_q.push_back(t[15:8]);
      frame_q.push_back(t[7:0]);
      for (int unsigned i = 0; i < plen; i++) frame_q.push_back(inc ? 8'(i) : 8'($urandom));
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         in_last  = 1'($urandom);
         in_error = 1'($urandom);
      end
   endtask

   // gap_mode: 0 none, 1 strict 1010, 2 random idles; stop>0 truncates without in_last
   task automatic send_frame(input int unsigned gap_mode, input logic err_last, input int unsigned stop);
      int unsigned  n;
      int unsigned  lim;
      int unsigned  c;
      logic [111:0] hdr;
      bit           acc;
      logic         lst;
      n   = frame_q.size();
      lim = (stop == 0) ? n : stop;
      hdr = '0;
      acc = 1'b0;
      for (int unsigned i = 0; i < lim; i++) begin
         if (gap_mode == 1 && i > 0) idle(1);
         if (gap_mode == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         @(posedge clk); #1;
         lst      = (i == n - 1);
         in_valid = 1'b1;
         in_data  = frame_q[i];
         in_last  = lst;
         in_error = lst ? err_last : 1'($urandom);
         c        = cyc;
         if (i < 14) begin
            hdr = {hdr[103:0], frame_q[i]};
            if (lst) begin
               model_drop(c);
            end else if (i == 13) begin
               if (mac_ok(hdr[111:64])) begin
                  acc = 1'b1;
                  hq.push_back('{c + 1, hdr[111:64], hdr[63:16], hdr[15:0]});
               end else begin
                  model_drop(c);
               end
            end
         end else if (acc) begin
            pq.push_back('{c + 1, frame_q[i], lst, lst & err_last});
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      exp_drop_m = 0;
      dq.push_back('{cyc + 1, 0});
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_hdr_valid", 64'(hdr_valid), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last",  64'(out_last),  64'd0);
      chk("rst_out_error", 64'(out_error), 64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_dst",       64'(dst_mac),   64'd0);
      chk("rst_src",       64'(src_mac),   64'd0);
      chk("rst_type",      64'(ethertype), 64'd0);
      chk("rst_drop",      64'(drop_count), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned o0;
      int unsigned h0;
      int unsigned k;
      logic [47:0] rd;
      repeat (3) @(posedge clk);
      do_reset();

      // 64-byte broadcast IPv4 frame, incrementing payload
      o0 = out_cnt;
      build(BCAST, 48'h00_11_22_33_44_55, 16'h0800, 50, 1'b1);
      send_frame(0, 1'b0, 0);
      idle(4);
      chk("f64_dst",   64'(dst_mac),   64'hffff_ffff_ffff);
      chk("f64_src",   64'(src_mac),   64'h0011_2233_4455);
      chk("f64_type",  64'(ethertype), 64'h0800);
      chk("f64_count", 64'(out_cnt - o0), 64'd50);
      chk("f64_lastd", 64'(last_out_data), 64'h31);
      chk("f64_err",   64'(last_out_err), 64'd0);

      // 10-byte runt then 20-byte frame, back-to-back
      o0 = out_cnt;
      build(BCAST, 48'h0a0b0c0d0e0f, 16'h86dd, 0, 1'b1);
      while (frame_q.size() > 10) void'(frame_q.pop_back());
      send_frame(0, 1'b0, 0);
      build(BCAST, 48'h0a0b0c0d0e0f, 16'h86dd, 6, 1'b0);
      send_frame(0, 1'b0, 0);
      idle(4);
      chk("runt10_drop", 64'(drop_count), 64'd1);
      chk("f20_count",   64'(out_cnt - o0), 64'd6);

      // 1010 strobe pattern with error on last
      o0 = out_cnt;
      build(BCAST, 48'h00_11_22_33_44_55, 16'h0800, 50, 1'b1);
      send_frame(1, 1'b1, 0);
      idle(4);
      chk("gap_count", 64'(out_cnt - o0), 64'd50);
      chk("gap_lastd", 64'(last_out_data), 64'h31);
      chk("gap_err",   64'(last_out_err), 64'd1);

      // two 60-byte frames with no idle between
      build(BCAST, 48'h665544332211, 16'h0806, 46, 1'b0);
      send_frame(0, 1'b0, 0);
      build(BCAST, 48'h665544332212, 16'h0806, 46, 1'b0);
      send_frame(0, 1'b0, 0);
      idle(4);
      k = hdr_cycles.size();
      chk("b2b_spacing", 64'(hdr_cycles[k-1] - hdr_cycles[k-2]), 64'd60);

      // reset while forwarding payload byte 5, then a clean frame
      build(BCAST, 48'h123456789abc, 16'h0800, 20, 1'b1);
      send_frame(0, 1'b0, 19);
      do_reset();
      o0 = out_cnt;
      build(BCAST, 48'h123456789abd, 16'h0801, 10, 1'b1);
      send_frame(0, 1'b0, 0);
      idle(4);
      chk("post_rst_count", 64'(out_cnt - o0), 64'd10);

`ifdef ETH_L2_MAC_FILTER_EN
      do_reset();
      o0 = out_cnt;
      h0 = hdr_cnt;
      build(48'h02_00_00_00_00_02, 48'h0a0a0a0a0a0a, 16'h0800, 16, 1'b1);
      send_frame(0, 1'b0, 0);
      idle(4);
      chk("flt_rej_drop", 64'(drop_count), 64'd1);
      chk("flt_rej_hdr",  64'(hdr_cnt - h0), 64'd0);
      chk("flt_rej_out",  64'(out_cnt - o0), 64'd0);
      build(48'h02_00_00_00_00_02, 48'h0a0a0a0a0a0a, 16'h0800, 0, 1'b1);
      send_frame(0, 1'b0, 0);
      idle(4);
      chk("flt_runt_once", 64'(drop_count), 64'd2);
      build(LMAC, 48'h0a0a0a0a0a0a, 16'h0800, 16, 1'b1);
      send_frame(0, 1'b0, 0);
      idle(4);
      chk("flt_acc_hdr", 64'(hdr_cnt - h0), 64'd1);
      chk("flt_acc_out", 64'(out_cnt - o0), 64'd16);
`endif

      // boundaries: 14-byte runt, 15-byte minimum frame, drop counter saturation
      do_reset();
      build(BCAST, 48'h0b0b0b0b0b0b, 16'h0800, 0, 1'b1);
      send_frame(0, 1'b0, 0);
      idle(3);
      chk("runt14_drop", 64'(drop_count), 64'd1);
      o0 = out_cnt;
      build(BCAST, 48'h0b0b0b0b0b0c, 16'h0800, 1, 1'b1);
      send_frame(0, 1'b1, 0);
      idle(3);
      chk("min15_count", 64'(out_cnt - o0), 64'd1);
      chk("min15_err",   64'(last_out_err), 64'd1);
      for (int i = 0; i < 8; i++) begin
         build(BCAST, 48'h0c0c0c0c0c0c, 16'h0800, 0, 1'b0);
         k = $urandom_range(1, 14);
         while (frame_q.size() > k) void'(frame_q.pop_back());
         send_frame(0, 1'b0, 0);
      end
      idle(3);
      chk("drop_saturate", 64'(drop_count), 64'(DMAX));

      // randomized traffic
      do_reset();
      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 2);
         rd = (k == 0) ? BCAST : (k == 1) ? LMAC : {$urandom, 16'($urandom)};
         build(rd, {$urandom, 16'($urandom)}, 16'($urandom), $urandom_range(0, 60), 1'b0);
         if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(1, frame_q.size());
            while (frame_q.size() > k) void'(frame_q.pop_back());
         end
         send_frame($urandom_range(0, 2), 1'($urandom), 0);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
      end
      idle(8);
      chk("final_hdr_q_empty", 64'(hq.size()), 64'd0);
      chk("final_out_q_empty", 64'(pq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eth_l2_header_parser.md
# eth_l2_header_parser

Receive-side layer-2 stage between the MAC byte receiver and `ethernet_controller`. Consumes the de-framed byte stream (preamble/SFD and FCS already stripped), captures the 14-byte Ethernet header into `dst_mac`, `src_mac` and `ethertype`, then forwards the payload bytes as a stream. The controller dispatches on `ethertype`. Frames too short to carry a header are dropped and counted.

## Interface
Parameters:
- `LOCAL_MAC`, default 48'h02_00_00_00_00_01. Station address used by the optional filter.
- `DROP_CNT_W`, default 16. Width of the drop counter.

Ports:
- `clk`  in  1  Single clock.
- `rst`  in  1  Reset, synchronous and active-high.
- `in_data`  in  8  Frame byte. The first byte is dst_mac[47:40].
- `in_valid`  in  1  Byte strobe. Gaps are allowed; there is no backpressure.
- `in_last`  in  1  Qualifies the final byte of the frame.
- `in_error`  in  1  Bad-frame flag from upstream, sampled with `in_last`.
- `hdr_valid`  out  1  One-cycle pulse: header fields are valid.
- `dst_mac` / `src_mac`  out  48  Captured MACs. Held until the next `hdr_valid`.
- `ethertype`  out  16  Big-endian as on the wire. Held until the next `hdr_valid`.
- `out_data`  out  8  Payload byte.
- `out_valid` / `out_last` / `out_error`  out  1  Payload strobe, end of frame, and error. `out_error` is valid only with `out_last`.
- `drop_count`  out  `DROP_CNT_W`  Saturating count of dropped frames.

## Operation
States:
- IDLE: next valid byte is header byte 0.
- HDR: counting bytes 0–13.
- PAYLOAD: forwarding bytes.
- DISCARD: consuming bytes until `in_last`.

Behaviour:
- The 4-bit byte counter and the state advance only on `in_valid`.
- Header bytes are shifted MSB-first into the dst/src/type registers. Output registers update only at byte 13.
- On byte 13 without `in_last`, pulse `hdr_valid` and enter PAYLOAD.
- Runt: `in_last` on any byte 0–13 drops the frame. No `hdr_valid`, increment `drop_count`, return to IDLE.
- A frame needs at least 1 payload byte.
- In PAYLOAD, each byte is forwarded. On `in_last`, assert `out_last`, set `out_error = in_error`, and go to IDLE.
- `in_error` without `in_last` is ignored.
- `drop_count` saturates at all-ones; it does not wrap.

Reset values:
- IDLE state, counter 0.
- `hdr_valid`, `out_valid`, `out_last`, `out_error` = 0.
- `out_data`, `dst_mac`, `src_mac`, `ethertype`, `drop_count` = 0.

Reset mid-frame:
- Go to IDLE immediately and clear all outputs, with no `out_last`.
- Upstream must be reset in the same cycle, so the next byte is a frame start.

## Timing
- All outputs are registered.
- `hdr_valid` is asserted in the cycle after byte 13 is accepted.
- Payload latency is 1 cycle: a byte accepted in cycle N appears on `out_*` in N+1.
- `hdr_valid` always precedes the frame's first `out_valid` by at least 1 cycle.
- Back-to-back frames: header byte 0 may follow `in_last` in the next cycle. The parser sustains 1 byte/clk indefinitely.
- `drop_count` updates in the cycle after the runt's `in_last`.

## Configuration
- `ETH_L2_MAC_FILTER_EN` defined: at byte 13, accept only if `dst_mac` equals `LOCAL_MAC` or ff:ff:ff:ff:ff:ff.
  - Accepted: behaves as above.
  - Rejected, non-runt: suppress `hdr_valid`, enter DISCARD, increment `drop_count`.
  - Rejected with `in_last` on byte 13: counts as a runt, counted once.
- Undefined: all frames are passed and there is no filter logic.

## Structure
- `eth_pkg` holds:
  - `mac_t` (logic [47:0]) and `ethertype_t` (logic [15:0]).
  - `ETH_HDR_LEN = 14` and `MAC_BROADCAST`.
  - The parser state enum.
- One sub-module, `eth_mac_match`: registered compare of the captured dst against `LOCAL_MAC`/broadcast. Instantiated only under the macro.

## Test plan
- 64-byte frame, dst ff:ff:ff:ff:ff:ff, src 00:11:22:33:44:55, type 0x0800, payload 0x00..0x31 -> one `hdr_valid` with those fields; 50 `out_valid` bytes 0x00..0x31; `out_last` on 0x31; `out_error` = 0.
- 10-byte frame, then a 20-byte frame -> no `hdr_valid` for the first frame, `drop_count` = 1; second frame parses with 6 payload bytes.
- Frame with `in_valid` toggling 1010… and `in_error` = 1 on last -> same data as the gapless case; `out_error` = 1 with `out_last`.
- Two 60-byte frames back-to-back, no idle -> two `hdr_valid` pulses 60 cycles apart; no byte lost or duplicated.
- `rst` asserted at payload byte 5 -> all outputs 0 next cycle; the following frame parses correctly.
- Macro on, dst = 02:00:00:00:00:02 -> no `hdr_valid`, no `out_valid`, `drop_count` = 1. Then dst = `LOCAL_MAC` -> passed.
